// File: rtl/cpu_pkg.sv
// Shared MIPS_CPU definitions: fetch FSM states, reset PC, instruction width and
// the opcode/funct encodings decoded by control.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          INSTR_W      = 32;

    localparam logic [5:0] OP_LW     = 6'b001000;
    localparam logic [5:0] OP_SW     = 6'b001001;
    localparam logic [5:0] OP_RTYPE  = 6'b000111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_MUL = 6'b110010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: holds, steps by PC_STEP, or loads a redirect target
// when the fetch FSM advances.
module pc_reg import cpu_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next-PC select; the add wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            if (redirect) begin
                pc_d = redirect_pc;
            end else begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // PC storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack handshake to instruction memory and the
// instruction register that feeds control.entrada.
module instr_fetch import cpu_pkg::*; #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid
);

    fetch_state_e       state_d, state_q;
    logic               req_d, req_q;
    logic               valid_d, valid_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               advance_s;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance_s),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    // Fetch FSM next-state; instr is forced to zero whenever it is not valid so
    // control sees a bubble (opcode 000000).
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        advance_s = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
                req_d   = 1'b1;
            end
            FETCH_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = FETCH_HOLD;
                end else begin
                    req_d   = 1'b1;
                    state_d = FETCH_REQ;
                end
            end
            FETCH_HOLD: begin
                if (stall) begin
                    state_d = FETCH_HOLD;
                end else begin
                    advance_s = 1'b1;
                    instr_d   = {INSTR_W{1'b0}};
                    valid_d   = 1'b0;
                    req_d     = 1'b1;
                    state_d   = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
                instr_d = {INSTR_W{1'b0}};
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any pending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= {INSTR_W{1'b0}};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory responder with random wait states,
// stall/redirect stimulus, and a monitor checking each delivered instruction.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0000_0000;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;
    logic        prev_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h23E0_1500;
        if (a == 32'h0000_0004) return 32'h1C43_2AA0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each rising instr_valid must deliver the next expected word.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr actual=%h expected=none", instr);
            end else begin
                e = sb.pop_front();
                chk("mon_pc", pc, e.pc);
                chk("mon_instr", instr, e.instr);
            end
        end
        if (!instr_valid) chk("bubble_zero", instr, 32'h0000_0000);
        prev_valid = instr_valid;
    end

    // One fetch at model_pc: w wait states, s stall cycles, then advance.
    task automatic fetch_one(input int w, input int s, input logic rd, input logic [31:0] tgt);
        int   n;
        logic got;
        exp_t e;
        got = 1'b0;
        for (n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            redirect = 1'b0;
            stall    = 1'b0;
            if (imem_req) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 expected=1 at %0t", $time);
            return;
        end
        chk("req_rise_cycles", 32'(n), 32'd1);
        chk("req_addr", imem_addr, model_pc);
        for (int i = 0; i < w; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, model_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(model_pc);
        e.pc       = model_pc;
        e.instr    = imem_rdata;
        sb.push_back(e);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("hold_no_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < s; i++) begin
            stall       = 1'b1;
            redirect    = rd ? 1'b1 : 1'($urandom_range(0, 1));
            redirect_pc = rd ? tgt : $urandom;
            @(negedge clk);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, model_pc);
            chk("stall_instr", instr, mem_word(model_pc));
        end
        stall       = 1'b0;
        redirect    = rd;
        redirect_pc = rd ? tgt : $urandom;
        model_pc    = rd ? tgt : model_pc + 32'd4;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'h0000_0000);
        chk({tag, "_pc"}, pc, 32'h0000_0000);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        rst      = 1'b0;
        model_pc = 32'h0000_0000;
        @(posedge clk);
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);

        fetch_one(0, 0, 1'b0, 32'h0);                // LW at 0x0
        fetch_one(0, 0, 1'b0, 32'h0);                // ADD at 0x4
        fetch_one(3, 0, 1'b0, 32'h0);                // 3 wait states at 0x8
        fetch_one(0, 5, 1'b1, 32'h0000_0040);        // stall with redirect held
        fetch_one(0, 0, 1'b1, 32'h0000_0100);
        fetch_one(0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(0, 0, 1'b0, 32'h0);                // wraps to 0
        fetch_one(1, 0, 1'b0, 32'h0);

        // Reset while REQ is pending and ack arrives the same cycle.
        @(negedge clk);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        check_reset_state("rst_late_ack");
        imem_ack = 1'b0;
        rst      = 1'b0;
        model_pc = 32'h0000_0000;
        @(posedge clk);
        #1;
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        fetch_one(0, 0, 1'b0, 32'h0);

        for (int k = 0; k < 30; k++) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2),
                      1'($urandom_range(0, 3) == 0), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS_CPU datapath. It holds the program counter and issues read requests to instruction memory with a req/ack handshake. It latches the returned word into an instruction register whose output drives the 32-bit `entrada` input of `control`. Stall and branch/jump redirect inputs let downstream stages freeze or retarget fetch.

## Interface
Parameters:
- `ADDR_W`, 32, width of the PC and instruction-memory address.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `PC_STEP`, 4, byte increment between sequential instructions.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  ADDR_W  read address; equals `pc` whenever `imem_req`=1.
- `imem_ack`  in  1  memory has valid data on `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `stall`  in  1  hold the current instruction and do not advance the PC.
- `redirect`  in  1  load `redirect_pc` instead of PC+PC_STEP on the next advance.
- `redirect_pc`  in  ADDR_W  branch/jump target.
- `pc`  out  ADDR_W  address of the instruction held in `instr`.
- `instr`  out  32  instruction register; connects to `control.entrada`.
- `instr_valid`  out  1  `instr` holds a fetched word.

## Operation
- The FSM has three states: IDLE, REQ and HOLD.
- **IDLE**
  - Entered only by reset.
  - Moves to REQ unconditionally on the next edge.
- **REQ**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - If `imem_ack`=1 on an edge: `instr` ← `imem_rdata`, `instr_valid` ← 1, next state HOLD.
  - Otherwise stay in REQ with the address stable. Never drop `imem_req` before ack.
  - `stall` and `redirect` are ignored in REQ.
- **HOLD**
  - `imem_req`=0. `instr` and `pc` are held.
  - If `stall`=1: stay in HOLD. `stall` has priority over `redirect`.
  - If `stall`=0 and `redirect`=1: `pc` ← `redirect_pc`.
  - If `stall`=0 and `redirect`=0: `pc` ← `pc` + `PC_STEP`.
  - When `stall`=0: `instr_valid` ← 0, next state REQ.
- **PC arithmetic**
  - Unsigned, ADDR_W bits, wraps modulo 2^ADDR_W (e.g. 32'hFFFF_FFFC + 4 = 0).
  - `redirect_pc` is loaded as given. Low bits are not masked.
- **Bubble**
  - While `instr_valid`=0, `instr` is 32'h0000_0000.
  - Opcode 000000 is not a valid instruction, so `control` emits no write enables for a bubble.
- **Reset**
  - Reset may arrive in any state, including REQ with a pending ack.
  - It aborts the transaction immediately: state IDLE, `imem_req`=0, and any late ack is ignored.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `imem_req`=0, `imem_addr`=RESET_PC, state IDLE.
- First request: `imem_req` rises on the first rising edge after `rst` deasserts (the IDLE→REQ edge).
- Latency: the ack edge loads `instr` and raises `instr_valid` on that same edge.
- Throughput: with ack in the first REQ cycle and no stall, one instruction every 2 cycles.
- Wait states:
  - N cycles of `imem_ack`=0 add N cycles in REQ.
  - `imem_addr` is constant throughout.
- `imem_req`, `instr_valid` and `pc` are pure state/register decodes with no combinational path from inputs.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum (`FETCH_IDLE`, `FETCH_REQ`, `FETCH_HOLD`).
  - `RESET_PC` default and `INSTR_W`=32.
  - Opcode constants used by `control`: LW 6'b001000, SW 6'b001001, R-type 6'b000111.
  - Funct constants: ADD 6'b100000, SUB 6'b100010, MUL 6'b110010, AND 6'b100100, OR 6'b100101.
- One natural sub-module: `pc_reg`, holding the PC register with increment/redirect/hold select and async reset.
- The FSM and instruction register stay in `instr_fetch`.

## Test plan
- Reset then zero-wait memory returning 32'h23E01500 (LW) at 0x0 and 32'h1C432AA0 (ADD) at 0x4 → `instr` shows LW with `pc`=0, then ADD with `pc`=4, `instr_valid` high every other cycle.
- Ack delayed 3 cycles → `imem_req` held high 4 cycles with `imem_addr` stable; `instr` updates only on the ack edge.
- `stall`=1 for 5 cycles in HOLD with `redirect`=1 throughout → `instr`, `pc` and `instr_valid` frozen and no request issued. On release, `pc` = `redirect_pc` (e.g. 0x40).
- `redirect`=1 with `redirect_pc`=0x100 in HOLD → next `imem_addr`=0x100, no request to PC+4.
- `pc`=32'hFFFF_FFFC advance → next `imem_addr`=0.
- `rst` asserted mid-REQ with ack arriving the same cycle → `imem_req`=0 and `instr`=0 immediately; after release, fetch restarts at RESET_PC.
